// File: rtl/pool_write_arbiter.sv
// Collects pooled results from POOL_NUM lanes into per-lane FIFOs and
// serialises them round-robin onto one registered write port per layer.
module pool_write_arbiter #(
  parameter int POOL_NUM      = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 10,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start_i,
  input  logic [POOL_NUM-1:0]                         pool_last_i,
  input  logic [POOL_NUM-1:0]                         pool_valid_i,
  input  logic [POOL_NUM-1:0][DATA_WIDTH-1:0]         pool_result_i,
  input  logic [POOL_NUM-1:0][ADDRESS_WIDTH-1:0]      pool_result_address_i,
  output logic                                        wr_valid_o,
  input  logic                                        wr_ready_i,
  output logic [DATA_WIDTH-1:0]                       wr_data_o,
  output logic [$clog2(POOL_NUM)+ADDRESS_WIDTH-1:0]   wr_addr_o,
  output logic                                        wr_last_o,
  output logic                                        busy_o,
  output logic                                        layer_done_o,
  output logic                                        overflow_o,
  output logic [1:0]                                  state_o
);

  localparam int LANE_W  = $clog2(POOL_NUM);
  localparam int SUM_W   = LANE_W + 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 1 + ADDRESS_WIDTH + DATA_WIDTH;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [ENTRY_W-1:0]              mem [POOL_NUM][FIFO_DEPTH];
  logic [POOL_NUM-1:0][PTR_W-1:0]  wr_ptr;
  logic [POOL_NUM-1:0][PTR_W-1:0]  rd_ptr;
  logic [POOL_NUM-1:0][CNT_W-1:0]  count;
  logic [POOL_NUM-1:0]             last_seen;
  logic [POOL_NUM-1:0]             empty;
  logic [POOL_NUM-1:0]             full;
  logic [POOL_NUM-1:0]             push;
  logic [POOL_NUM-1:0]             pop;
  logic [POOL_NUM-1:0]             drop;
  logic [LANE_W-1:0]               rr_ptr;
  logic [LANE_W-1:0]               grant_idx;
  logic                            grant_valid;
  logic [SUM_W-1:0]                idx_sum;
  logic                            out_free;
  logic                            grant_fire;
  logic                            clear_lanes;
  logic                            all_empty;
  logic [ENTRY_W-1:0]              head;

  // Write port handshake: an entry transfers on a rising edge where
  // wr_valid_o and wr_ready_i are both high; while wr_valid_o is high and
  // wr_ready_i low, data/addr/last hold and no lane is popped.
  assign out_free    = !wr_valid_o || wr_ready_i;
  assign grant_fire  = grant_valid && out_free;
  assign clear_lanes = (state == IDLE) && start_i;
  assign all_empty   = &empty;
  assign head        = mem[grant_idx][rd_ptr[grant_idx]];

  always_comb begin
    empty = '0;
    full  = '0;
    for (int k = 0; k < POOL_NUM; k++) begin
      empty[k] = (count[k] == '0);
      full[k]  = (count[k] == FULL_CNT);
    end
  end

  // Round-robin search beginning at rr_ptr, wrapping modulo POOL_NUM.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx_sum     = '0;
    for (int i = 0; i < POOL_NUM; i++) begin
      idx_sum = {1'b0, rr_ptr} + SUM_W'(i);
      if (idx_sum >= SUM_W'(POOL_NUM)) idx_sum = idx_sum - SUM_W'(POOL_NUM);
      if (!grant_valid && !empty[idx_sum[LANE_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = idx_sum[LANE_W-1:0];
      end
    end
  end

  always_comb begin
    pop  = '0;
    push = '0;
    drop = '0;
    if (grant_fire) pop[grant_idx] = 1'b1;
    for (int k = 0; k < POOL_NUM; k++) begin
      push[k] = pool_valid_i[k] && (state == RUN) && !last_seen[k] && (!full[k] || pop[k]);
      drop[k] = pool_valid_i[k] && !push[k];
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < POOL_NUM; k++) begin
      if (push[k]) mem[k][wr_ptr[k]] <= {pool_last_i[k], pool_result_address_i[k], pool_result_i[k]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_lanes) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_seen <= '0;
    end else begin
      for (int k = 0; k < POOL_NUM; k++) begin
        if (push[k]) begin
          wr_ptr[k] <= wr_ptr[k] + 1'b1;
          if (pool_last_i[k]) last_seen[k] <= 1'b1;
        end
        if (pop[k]) rd_ptr[k] <= rd_ptr[k] + 1'b1;
        if (push[k] && !pop[k])      count[k] <= count[k] + 1'b1;
        else if (!push[k] && pop[k]) count[k] <= count[k] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_lanes) begin
      rr_ptr <= '0;
    end else if (grant_fire) begin
      rr_ptr <= (grant_idx == LANE_W'(POOL_NUM - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_valid_o <= 1'b0;
      wr_data_o  <= '0;
      wr_addr_o  <= '0;
      wr_last_o  <= 1'b0;
    end else if (grant_fire) begin
      wr_valid_o <= 1'b1;
      wr_data_o  <= head[DATA_WIDTH-1:0];
      wr_addr_o  <= {grant_idx, head[DATA_WIDTH +: ADDRESS_WIDTH]};
      wr_last_o  <= head[ENTRY_W-1];
    end else if (wr_ready_i) begin
      wr_valid_o <= 1'b0;
    end
  end

  // Starting a layer wins over a stray lane result seen in the same IDLE cycle.
  always_ff @(posedge clk) begin
    if (rst || clear_lanes) overflow_o <= 1'b0;
    else if (|drop)         overflow_o <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_i) state_nxt = RUN;
      RUN:   if (&last_seen) state_nxt = DRAIN;
      DRAIN: if (all_empty && out_free) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_o       = (state == RUN) || (state == DRAIN);
  assign layer_done_o = (state == DONE);
  assign state_o      = state;

endmodule

// File: tb/tb_pool_write_arbiter.sv
// Directed scoreboard bench for pool_write_arbiter: drivers queue expected
// writes, a negedge monitor pops and compares every accepted write.
module tb_pool_write_arbiter;

  localparam int POOL_NUM      = 16;
  localparam int DATA_WIDTH    = 8;
  localparam int ADDRESS_WIDTH = 10;
  localparam int FIFO_DEPTH    = 4;
  localparam int LANE_W        = 4;
  localparam int W             = 1 + LANE_W + ADDRESS_WIDTH + DATA_WIDTH;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic                                     clk;
  logic                                     rst;
  logic                                     start_i;
  logic [POOL_NUM-1:0]                      pool_last_i;
  logic [POOL_NUM-1:0]                      pool_valid_i;
  logic [POOL_NUM-1:0][DATA_WIDTH-1:0]      pool_result_i;
  logic [POOL_NUM-1:0][ADDRESS_WIDTH-1:0]   pool_result_address_i;
  logic                                     wr_valid_o;
  logic                                     wr_ready_i;
  logic [DATA_WIDTH-1:0]                    wr_data_o;
  logic [LANE_W+ADDRESS_WIDTH-1:0]          wr_addr_o;
  logic                                     wr_last_o;
  logic                                     busy_o;
  logic                                     layer_done_o;
  logic                                     overflow_o;
  logic [1:0]                               state_o;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  int n_tests = 0;
  int n_fail  = 0;

  pool_write_arbiter #(
    .POOL_NUM(POOL_NUM), .DATA_WIDTH(DATA_WIDTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .pool_last_i(pool_last_i), .pool_valid_i(pool_valid_i),
    .pool_result_i(pool_result_i), .pool_result_address_i(pool_result_address_i),
    .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i),
    .wr_data_o(wr_data_o), .wr_addr_o(wr_addr_o), .wr_last_o(wr_last_o),
    .busy_o(busy_o), .layer_done_o(layer_done_o), .overflow_o(overflow_o),
    .state_o(state_o)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && wr_valid_o && wr_ready_i) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got %0h, expected no write", {wr_last_o, wr_addr_o, wr_data_o});
      end else begin
        mon_exp = exp_q.pop_front();
        check("wr_beat", 32'({wr_last_o, wr_addr_o, wr_data_o}), 32'(mon_exp));
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start_i = 1'b0;
    pool_valid_i = '0;
    pool_last_i = '0;
    wr_ready_i = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic start_layer();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic drive_lane(input int lane, input logic [7:0] data, input logic [9:0] addr,
                            input logic last, input logic accept);
    pool_valid_i[lane] = 1'b1;
    pool_last_i[lane] = last;
    pool_result_i[lane] = data;
    pool_result_address_i[lane] = addr;
    if (accept) exp_q.push_back({last, LANE_W'(lane), addr, data});
    tick();
    pool_valid_i = '0;
    pool_last_i = '0;
  endtask

  task automatic drive_all(input logic last, input logic [7:0] base);
    for (int k = 0; k < POOL_NUM; k++) begin
      pool_valid_i[k] = 1'b1;
      pool_last_i[k] = last;
      pool_result_i[k] = 8'(base + 8'(k));
      pool_result_address_i[k] = 10'(k * 3);
      exp_q.push_back({last, LANE_W'(k), 10'(k * 3), 8'(base + 8'(k))});
    end
    tick();
    pool_valid_i = '0;
    pool_last_i = '0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    check(name, exp_q.size(), 0);
    tick();
    tick();
  endtask

  task automatic run_layer_end(input string name, input logic toggle);
    int pulses;
    logic saw_drain;
    logic prev_busy;
    pulses = 0;
    saw_drain = 1'b0;
    prev_busy = busy_o;
    for (int i = 0; i < 80; i++) begin
      if (toggle) wr_ready_i = ~wr_ready_i;
      tick();
      if (state_o == S_DRAIN) saw_drain = 1'b1;
      if (layer_done_o) begin
        pulses++;
        if (pulses == 1) begin
          check({name, "_busy_fall"}, busy_o, 0);
          check({name, "_busy_before"}, prev_busy, 1);
          check({name, "_all_written"}, exp_q.size(), 0);
        end
      end
      prev_busy = busy_o;
    end
    check({name, "_saw_drain"}, saw_drain, 1);
    check({name, "_done_pulses"}, pulses, 1);
    check({name, "_idle"}, state_o, S_IDLE);
  endtask

  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    pool_valid_i = '0;
    pool_last_i = '0;
    pool_result_i = '0;
    pool_result_address_i = '0;
    wr_ready_i = 1'b0;

    // reset values
    do_reset();
    check("rst_wr_valid", wr_valid_o, 0);
    check("rst_wr_data", wr_data_o, 0);
    check("rst_wr_addr", wr_addr_o, 0);
    check("rst_wr_last", wr_last_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", layer_done_o, 0);
    check("rst_overflow", overflow_o, 0);
    check("rst_state", state_o, S_IDLE);

    // single entry, two-cycle latency
    start_layer();
    check("run_busy", busy_o, 1);
    check("run_state", state_o, S_RUN);
    wr_ready_i = 1'b1;
    drive_lane(3, 8'h5A, 10'h010, 1'b1, 1'b1);
    check("lat1_valid", wr_valid_o, 0);
    tick();
    check("lat2_valid", wr_valid_o, 1);
    check("lat2_data", wr_data_o, 8'h5A);
    check("lat2_addr", wr_addr_o, 14'h0C10);
    check("lat2_last", wr_last_o, 1);
    wait_drain("single_drain", 10);

    // all lanes at once: lanes 0..15 back to back
    do_reset();
    start_layer();
    wr_ready_i = 1'b1;
    drive_all(1'b0, 8'h10);
    tick();
    for (int i = 0; i < POOL_NUM; i++) begin
      check("burst_valid", wr_valid_o, 1);
      tick();
    end
    check("burst_end_valid", wr_valid_o, 0);
    check("burst_overflow", overflow_o, 0);
    wait_drain("burst_drain", 5);

    // backpressure on lane 0: the output register absorbs the first entry,
    // so the FIFO fills on the fifth push and the sixth is dropped
    do_reset();
    start_layer();
    for (int i = 0; i < 6; i++) begin
      drive_lane(0, 8'(8'hA0 + 8'(i)), 10'(10'h100 + 10'(i)), 1'b0, i < 5);
      if (i == 4) check("bp_no_overflow_yet", overflow_o, 0);
    end
    check("bp_overflow", overflow_o, 1);
    for (int i = 0; i < 4; i++) begin
      check("bp_hold_valid", wr_valid_o, 1);
      check("bp_hold_data", wr_data_o, 8'hA0);
      check("bp_hold_addr", wr_addr_o, 14'h0100);
      tick();
    end
    wr_ready_i = 1'b1;
    wait_drain("bp_drain", 20);

    // discards: push in IDLE, push after last
    do_reset();
    drive_lane(5, 8'h77, 10'h3FF, 1'b0, 1'b0);
    check("idle_push_overflow", overflow_o, 1);
    tick();
    tick();
    check("idle_push_no_write", wr_valid_o, 0);
    start_layer();
    check("start_clears_overflow", overflow_o, 0);
    wr_ready_i = 1'b1;
    drive_lane(2, 8'h22, 10'h002, 1'b1, 1'b1);
    check("last_push_ok", overflow_o, 0);
    drive_lane(2, 8'h23, 10'h003, 1'b0, 1'b0);
    check("after_last_overflow", overflow_o, 1);
    wait_drain("discard_drain", 10);

    // full layer with toggling ready
    do_reset();
    start_layer();
    wr_ready_i = 1'b1;
    drive_all(1'b1, 8'h40);
    run_layer_end("layer", 1'b1);

    // reset in the middle of DRAIN, then a clean layer
    do_reset();
    start_layer();
    drive_all(1'b1, 8'h60);
    for (int i = 0; i < 10 && state_o != S_DRAIN; i++) tick();
    check("mid_drain_state", state_o, S_DRAIN);
    check("mid_drain_valid", wr_valid_o, 1);
    rst = 1'b1;
    exp_q.delete();
    tick();
    check("mid_rst_valid", wr_valid_o, 0);
    check("mid_rst_data", wr_data_o, 0);
    check("mid_rst_addr", wr_addr_o, 0);
    check("mid_rst_last", wr_last_o, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_state", state_o, S_IDLE);
    rst = 1'b0;
    tick();
    start_layer();
    wr_ready_i = 1'b1;
    drive_all(1'b1, 8'hC0);
    run_layer_end("clean", 1'b0);
    check("clean_overflow", overflow_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
